mm_byte_bus_master: RTL
=======================

Name: mm_byte_bus_master

Overview:
- Host-side initiator for the memory_manager 8-bit byte bus.
- Accepts 16-bit word read/write requests from a host (loader/controller) and sequences them as two byte transactions on the memory_manager's data/address/wren_in interface.
- Byte order: even byte address carries the LS byte, odd byte address carries the MS byte.
- Sits between host logic and memory_manager; the top level merges data_out/data_oe/data_in into the tri-state data bus.

Parameters:
DATA_WIDTH, 8, byte-bus width
ADDRESS_WIDTH, 23, byte-bus address width
WORD_WIDTH, 16, host word width (= 2*DATA_WIDTH)
READ_LATENCY, 2, clk cycles a read address is held before data_in is sampled (legal range >= 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDRESS_WIDTH-1  word address
req_wdata  input  WORD_WIDTH  write data
resp_valid  output  1  one-cycle completion pulse, reads and writes
resp_rdata  output  WORD_WIDTH  read data, valid while resp_valid=1 and held afterwards
address  output  ADDRESS_WIDTH  byte address to memory_manager
wren  output  1  drives memory_manager wren_in
data_out  output  DATA_WIDTH  byte write data
data_oe  output  1  1 = master drives data bus
data_in  input  DATA_WIDTH  byte read data from data bus

Behaviour:
- Reset: all outputs are registered. During reset: state=IDLE, address=0, wren=0, data_oe=0, data_out=0, resp_valid=0, resp_rdata=0. Reset asserted mid-transaction aborts it immediately; no resp_valid is issued for the aborted request.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE. req_ready=1 only in IDLE, decoded from state.
- Accept: a request is accepted on the edge where state=IDLE and req_valid=1. req_addr, req_write and req_wdata are captured on that edge and ignored afterwards.
- Write path: IDLE -> WR_LO -> WR_HI -> DONE -> IDLE. Each write state lasts 1 cycle.
  - WR_LO: address={a,0}, data_out=wdata[7:0].
  - WR_HI: address={a,1}, data_out=wdata[15:8].
  - In both states wren=1 and data_oe=1.
- Read path: IDLE -> RD_LO -> RD_HI -> DONE -> IDLE.
  - RD_LO: address={a,0}, wren=0, data_oe=0, held exactly READ_LATENCY cycles. data_in is sampled into resp_rdata[7:0] on the last edge of RD_LO.
  - RD_HI: address={a,1}, same rules, data_in sampled into resp_rdata[15:8].
  - A latency counter (width sufficient for READ_LATENCY) is reset on each state entry.
- DONE: 1 cycle. resp_valid=1, wren=0, data_oe=0. address holds its last value.
- Latency from accept edge to the resp_valid cycle:
  - Write: 3 cycles.
  - Read: 2*READ_LATENCY+1 cycles.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE. There is no overlap or pipelining.
- resp_rdata is not modified by writes. It changes only at the read sample edges.
- Address boundary: word address 2^22-1 maps to bytes 0x7FFFFE and 0x7FFFFF. No wrap or carry occurs; the LSB is forced, not added.
- req_valid deasserted in non-IDLE states has no effect. A request presented while not ready is held by the host (standard valid/ready).
- data_oe is never 1 while wren=0. On read-to-write turnaround, at least one DONE/IDLE cycle has data_oe=0.

Test Plan:
1. Reset mid-write: assert rst_n=0 during WR_HI. Required: wren=0, data_oe=0, address=0 immediately (asynchronously), no resp_valid, and req_ready=1 after release.
2. Write word addr 0x000005, wdata 0xBEEF. Required:
   - WR_LO: address 0x00000A, data_out 0xEF, wren=1, data_oe=1.
   - WR_HI: address 0x00000B, data_out 0xBE.
   - resp_valid pulse 3 cycles after accept.
3. Read back addr 0x000005 through memory_manager+RAM with READ_LATENCY=2. Required: resp_rdata=0xBEEF, resp_valid exactly 5 cycles after accept, wren=0 and data_oe=0 throughout.
4. Write words 0..9 (data = 0x0100*i + i) back-to-back with req_valid held high, then read all 10 words. Required: every readback matches, req_ready=1 only between transactions, and no resp_valid is missing or duplicated.
5. Boundary: write addr 0x3FFFFF with data 0x1234. Required: byte addresses 0x7FFFFE/0x7FFFFF, then read returns 0x1234.
6. READ_LATENCY=1 rebuild, read with data_in driven 0xA5 then 0x5A. Required: resp_rdata=0x5AA5, resp_valid 3 cycles after accept.

Source files
------------

// File: rtl/mm_byte_bus_master.sv
// Host-side initiator for the memory_manager byte bus: turns one 16-bit word
// request into two byte transactions (LS byte at even address, MS byte at odd).
module mm_byte_bus_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 23,
    parameter int WORD_WIDTH    = 16,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-2:0] req_addr,
    input  logic [WORD_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [WORD_WIDTH-1:0]    resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     wren,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_oe,
    input  logic [DATA_WIDTH-1:0]    data_in
);

    localparam int                LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_RD_LO,
        S_RD_HI,
        S_DONE
    } state_t;

    state_t                     r_state,     w_stateNext;
    logic [ADDRESS_WIDTH-2:0]   r_addr,      w_addrNext;
    logic [DATA_WIDTH-1:0]      r_wdataHi,   w_wdataHiNext;
    logic [LAT_W-1:0]           r_lat,       w_latNext;
    logic [ADDRESS_WIDTH-1:0]   r_address,   w_addressNext;
    logic                       r_wren,      w_wrenNext;
    logic                       r_oe,        w_oeNext;
    logic [DATA_WIDTH-1:0]      r_dataOut,   w_dataOutNext;
    logic                       r_respValid, w_respValidNext;
    logic [WORD_WIDTH-1:0]      r_rdata,     w_rdataNext;
    logic                       w_latDone;

    // Every bus-facing output is computed one cycle ahead and registered, so
    // the byte address and strobes appear cleanly on the edge a state is entered.
    always_comb begin
        w_stateNext     = r_state;
        w_addrNext      = r_addr;
        w_wdataHiNext   = r_wdataHi;
        w_latNext       = r_lat;
        w_addressNext   = r_address;
        w_wrenNext      = 1'b0;
        w_oeNext        = 1'b0;
        w_dataOutNext   = r_dataOut;
        w_respValidNext = 1'b0;
        w_rdataNext     = r_rdata;
        w_latDone       = (r_lat == LAT_LAST);

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_addrNext    = req_addr;
                    w_wdataHiNext = req_wdata[WORD_WIDTH-1:DATA_WIDTH];
                    w_latNext     = '0;
                    w_addressNext = {req_addr, 1'b0};
                    if (req_write) begin
                        w_stateNext   = S_WR_LO;
                        w_wrenNext    = 1'b1;
                        w_oeNext      = 1'b1;
                        w_dataOutNext = req_wdata[DATA_WIDTH-1:0];
                    end else begin
                        w_stateNext   = S_RD_LO;
                    end
                end
            end
            S_WR_LO: begin
                w_stateNext   = S_WR_HI;
                w_addressNext = {r_addr, 1'b1};
                w_wrenNext    = 1'b1;
                w_oeNext      = 1'b1;
                w_dataOutNext = r_wdataHi;
            end
            S_WR_HI: begin
                w_stateNext     = S_DONE;
                w_respValidNext = 1'b1;
            end
            S_RD_LO: begin
                if (w_latDone) begin
                    w_rdataNext[DATA_WIDTH-1:0] = data_in;
                    w_stateNext   = S_RD_HI;
                    w_addressNext = {r_addr, 1'b1};
                    w_latNext     = '0;
                end else begin
                    w_latNext     = r_lat + LAT_W'(1);
                end
            end
            S_RD_HI: begin
                if (w_latDone) begin
                    w_rdataNext[WORD_WIDTH-1:DATA_WIDTH] = data_in;
                    w_stateNext     = S_DONE;
                    w_respValidNext = 1'b1;
                    w_latNext       = '0;
                end else begin
                    w_latNext       = r_lat + LAT_W'(1);
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdataHi   <= '0;
            r_lat       <= '0;
            r_address   <= '0;
            r_wren      <= 1'b0;
            r_oe        <= 1'b0;
            r_dataOut   <= '0;
            r_respValid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_addr      <= w_addrNext;
            r_wdataHi   <= w_wdataHiNext;
            r_lat       <= w_latNext;
            r_address   <= w_addressNext;
            r_wren      <= w_wrenNext;
            r_oe        <= w_oeNext;
            r_dataOut   <= w_dataOutNext;
            r_respValid <= w_respValidNext;
            r_rdata     <= w_rdataNext;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_respValid;
    assign resp_rdata = r_rdata;
    assign address    = r_address;
    assign wren       = r_wren;
    assign data_out   = r_dataOut;
    assign data_oe    = r_oe;

endmodule
